// File: rtl/alu_decoder.sv
// RV32I decode stage feeding the ALU through a two-entry in-order buffer (head + skid).
// Define ILLEGAL_HALT_EN to halt on an unsupported opcode instead of passing it on as a NOP.
module alu_decoder #(
    parameter int LEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [31:0]    in_inst,
    input  logic [LEN-1:0] in_pc,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2:0]     out_alu_signal,
    output logic [3:0]     out_func_code,
    output logic [LEN-1:0] out_imm,
    output logic [LEN-1:0] out_pc,
    output logic [4:0]     out_rs1,
    output logic [4:0]     out_rs2,
    output logic [4:0]     out_rd,
    output logic           illegal
);

    typedef enum logic [1:0] {EMPTY, ONE, TWO, HALT} state_e;

    typedef struct packed {
        logic [2:0]     alu;
        logic [3:0]     func;
        logic [LEN-1:0] imm;
        logic [LEN-1:0] pc;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic [4:0]     rd;
    } entry_t;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_NOP        = 3'd0;
    localparam logic [2:0] ALU_BINARY     = 3'd1;
    localparam logic [2:0] ALU_IMM_BINARY = 3'd2;
    localparam logic [2:0] ALU_BRANCH     = 3'd3;
    localparam logic [2:0] ALU_MEM_ADDR   = 3'd4;
    localparam logic [2:0] ALU_PC_BASED   = 3'd5;
    localparam logic [2:0] ALU_IMM        = 3'd6;

    function automatic logic [LEN-1:0] sext32(input logic [31:0] v);
        return LEN'(signed'(v));
    endfunction

    state_e       state_q, state_d;
    entry_t       head_q, skid_q, dec;
    logic         head_v_q, head_v_d, skid_v_q, skid_v_d;
    logic         in_ready_q, in_ready_d, illegal_q, illegal_d;
    logic         dec_illegal, accept, push, pop;
    logic [31:0]  imm32;

    always_comb begin
        imm32       = '0;
        dec         = '0;
        dec_illegal = 1'b0;
        dec.pc      = in_pc;
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.func    = {1'b0, in_inst[14:12]};
        case (in_inst[6:0])
            OPC_OP: begin
                dec.alu  = ALU_BINARY;
                dec.func = {in_inst[30], in_inst[14:12]};
            end
            OPC_OPIMM: begin
                dec.alu = ALU_IMM_BINARY;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_BRANCH: begin
                dec.alu = ALU_BRANCH;
                imm32   = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                           in_inst[11:8], 1'b0};
            end
            OPC_LOAD, OPC_JALR: begin
                dec.alu = ALU_MEM_ADDR;
                imm32   = {{20{in_inst[31]}}, in_inst[31:20]};
            end
            OPC_STORE: begin
                dec.alu = ALU_MEM_ADDR;
                imm32   = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            end
            OPC_AUIPC: begin
                dec.alu = ALU_PC_BASED;
                imm32   = {in_inst[31:12], 12'b0};
            end
            OPC_JAL: begin
                dec.alu = ALU_PC_BASED;
                imm32   = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                           in_inst[30:21], 1'b0};
            end
            OPC_LUI: begin
                dec.alu = ALU_IMM;
                imm32   = {in_inst[31:12], 12'b0};
            end
            default: begin
                dec_illegal = 1'b1;
                dec.func    = '0;
            end
        endcase
        dec.imm = sext32(imm32);
    end

    // Flush wins over both a simultaneous accept and a simultaneous drain.
    assign accept = in_valid && in_ready_q && !flush;
    assign pop    = head_v_q && out_ready && !flush;
`ifdef ILLEGAL_HALT_EN
    assign push   = accept && !dec_illegal;
`else
    assign push   = accept;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = TWO;
                else if (pop && !push) state_d = EMPTY;
            end
            TWO:     if (pop) state_d = ONE;
            HALT:    state_d = HALT;
            default: state_d = EMPTY;
        endcase
`ifdef ILLEGAL_HALT_EN
        if (accept && dec_illegal) state_d = HALT;
        illegal_d = illegal_q || (accept && dec_illegal);
`else
        illegal_d = accept && dec_illegal;
`endif
        if (flush) begin
            state_d   = EMPTY;
            illegal_d = 1'b0;
        end
        in_ready_d = (state_d == EMPTY) || (state_d == ONE);
        head_v_d   = pop ? (skid_v_q || push) : (head_v_q || push);
        skid_v_d   = pop ? 1'b0 : (skid_v_q || (push && head_v_q));
        if (flush) begin
            head_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            head_v_q   <= 1'b0;
            skid_v_q   <= 1'b0;
            in_ready_q <= 1'b1;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            head_v_q   <= head_v_d;
            skid_v_q   <= skid_v_d;
            in_ready_q <= in_ready_d;
            illegal_q  <= illegal_d;
        end
    end

    // Head reloads from skid on drain; a new entry lands in head only when head frees up.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= '0;
            skid_q <= '0;
        end else begin
            if (pop) begin
                if (skid_v_q)  head_q <= skid_q;
                else if (push) head_q <= dec;
            end else if (push && !head_v_q) begin
                head_q <= dec;
            end
            if (push && head_v_q && !pop) skid_q <= dec;
        end
    end

    assign in_ready       = in_ready_q;
    assign out_valid      = head_v_q;
    assign illegal        = illegal_q;
    assign out_alu_signal = head_q.alu;
    assign out_func_code  = head_q.func;
    assign out_imm        = head_q.imm;
    assign out_pc         = head_q.pc;
    assign out_rs1        = head_q.rs1;
    assign out_rs2        = head_q.rs2;
    assign out_rd         = head_q.rd;

endmodule

// File: tb/tb_alu_decoder.sv
// Self-checking bench for alu_decoder: directed decode vectors, backpressure, flush,
// reset, illegal-opcode handling and a randomized run against a queue-based model.
module tb_alu_decoder;
    localparam int LEN = 32;
    localparam int EW  = 3 + 4 + 2 * LEN + 15;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [31:0]    in_inst = '0;
    logic [LEN-1:0] in_pc = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2:0]     out_alu_signal;
    logic [3:0]     out_func_code;
    logic [LEN-1:0] out_imm, out_pc;
    logic [4:0]     out_rs1, out_rs2, out_rd;
    logic           illegal;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [EW-1:0] v;
        logic [EW-1:0] m;
    } exp_t;

    exp_t q[$];
    logic [EW-1:0] obs;
    logic [6:0] legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b1100011, 7'b0000011, 7'b0100011,
                                  7'b1100111, 7'b0010111, 7'b1101111, 7'b0110111};

    assign obs = {out_alu_signal, out_func_code, out_imm, out_pc, out_rs1, out_rs2, out_rd};

    alu_decoder #(.LEN(LEN)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_signal(out_alu_signal), .out_func_code(out_func_code), .out_imm(out_imm),
        .out_pc(out_pc), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // Reference decode: immediates are built by weighted arithmetic on instruction fields.
    function automatic logic [EW-1:0] model(input logic [31:0] i, input logic [LEN-1:0] pc,
                                            output bit ill);
        int v;
        logic [2:0] a;
        logic [3:0] f;
        logic signed [LEN-1:0] imm;
        int ineg;
        v = 0; a = 0; ill = 0;
        f = {1'b0, i[14:12]};
        ineg = i[31] ? -2048 : 0;
        case (i[6:0])
            7'b0110011: begin a = 1; f = {i[30], i[14:12]}; end
            7'b0010011: begin a = 2; v = ineg + int'(i[30:20]); end
            7'b1100011: begin
                a = 3;
                v = (i[31] ? -4096 : 0) + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
            end
            7'b0000011, 7'b1100111: begin a = 4; v = ineg + int'(i[30:20]); end
            7'b0100011: begin a = 4; v = ineg + int'(i[30:25]) * 32 + int'(i[11:7]); end
            7'b0010111: begin a = 5; v = int'(i[31:12]) * 4096; end
            7'b1101111: begin
                a = 5;
                v = (i[31] ? -1048576 : 0) + int'(i[19:12]) * 4096 + int'(i[20]) * 2048
                    + int'(i[30:21]) * 2;
            end
            7'b0110111: begin a = 6; v = int'(i[31:12]) * 4096; end
            default: begin ill = 1; f = 0; end
        endcase
        imm = v;
        return {a, f, imm, pc, i[19:15], i[24:20], i[11:7]};
    endfunction

    function automatic logic [EW-1:0] full_mask(input bit ill);
        logic [EW-1:0] m;
        m = '1;
        if (ill) m[14:0] = '0;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h, required 0", obs); end
        n_tests++;
        if (out_valid !== 1'b0 || illegal !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got valid=%b illegal=%b, required 0 0", out_valid, illegal);
        end
        rst_n = 1'b1;
        step();
        n_tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: got ready=%b valid=%b, required 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_vectors();
        logic [31:0] insts [4] = '{32'h00500093, 32'h402081B3, 32'hFE000EE3, 32'h123451B7};
        logic [2:0]  alus  [4] = '{3'd2, 3'd1, 3'd3, 3'd6};
        logic [31:0] imms  [4] = '{32'd5, 32'd0, 32'hFFFFFFFC, 32'h12345000};
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_inst = insts[k]; in_pc = 32'h100 + 32'(k * 4);
            step();
            n_tests++;
            if (out_valid !== 1'b1 || out_alu_signal !== alus[k] || out_imm !== imms[k]
                || out_pc !== 32'h100 + 32'(k * 4)) begin
                n_fail++;
                $display("FAIL vector%0d: got valid=%b alu=%0d imm=%h pc=%h, required 1 %0d %h %h",
                         k, out_valid, out_alu_signal, out_imm, out_pc, alus[k], imms[k], 32'h100 + 32'(k * 4));
            end
            if (k == 0) begin
                n_tests++;
                if (out_func_code !== 4'd0 || out_rd !== 5'd1) begin
                    n_fail++; $display("FAIL vector0_fields: got func=%h rd=%0d, required 0 1", out_func_code, out_rd);
                end
            end
            if (k == 1) begin
                n_tests++;
                if (out_func_code !== 4'b1000 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3) begin
                    n_fail++;
                    $display("FAIL vector1_fields: got func=%h rs1=%0d rs2=%0d rd=%0d, required 8 1 2 3",
                             out_func_code, out_rs1, out_rs2, out_rd);
                end
            end
        end
        in_valid = 1'b0;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL vector_drain: got valid=%b, required 0", out_valid); end
    endtask

    task automatic test_backpressure();
        logic [EW-1:0] ea, eb;
        bit ill;
        ea = model(32'h00500093, 32'h200, ill);
        eb = model(32'h402081B3, 32'h204, ill);
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h200;
        step();
        in_inst = 32'h402081B3; in_pc = 32'h204;
        step();
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || obs !== ea) begin
                n_fail++;
                $display("FAIL stall%0d: got ready=%b valid=%b out=%h, required 0 1 %h", k, in_ready, out_valid, obs, ea);
            end
            step();
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b1 || obs !== eb || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL second_out: got valid=%b ready=%b out=%h, required 1 1 %h", out_valid, in_ready, obs, eb);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got valid=%b, required 0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h400;
        step();
        step();
        in_inst = 32'h123451B7; out_ready = 1'b1; flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL flush: got valid=%b ready=%b illegal=%b, required 0 1 0", out_valid, in_ready, illegal);
        end
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_drop: got valid=%b, required 0", out_valid); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h500;
        step();
        step();
        in_valid = 1'b0; out_ready = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || obs !== '0) begin
            n_fail++; $display("FAIL async_reset: got valid=%b out=%h, required 0 0", out_valid, obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_discard: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_illegal();
        out_ready = 1'b0;
`ifdef ILLEGAL_HALT_EN
        in_valid = 1'b1; in_inst = 32'h00500093; in_pc = 32'h600;
        step();
        in_inst = 32'hFFFFFFFF; in_pc = 32'h604;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (illegal !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h600) begin
            n_fail++;
            $display("FAIL halt_enter: got illegal=%b ready=%b valid=%b pc=%h, required 1 0 1 600",
                     illegal, in_ready, out_valid, out_pc);
        end
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (illegal !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL halt_hold%0d: got illegal=%b ready=%b valid=%b, required 1 0 0",
                         k, illegal, in_ready, out_valid);
            end
        end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_tests++;
        if (illegal !== 1'b0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_flush: got illegal=%b ready=%b valid=%b, required 0 1 0", illegal, in_ready, out_valid);
        end
`else
        in_valid = 1'b1; in_inst = 32'hFFFFFFFF; in_pc = 32'h600;
        step();
        in_valid = 1'b0;
        n_tests++;
        if (illegal !== 1'b1 || out_valid !== 1'b1 || out_alu_signal !== 3'd0 || out_imm !== '0
            || out_func_code !== 4'd0 || in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL nop_entry: got illegal=%b valid=%b alu=%0d imm=%h func=%h ready=%b, required 1 1 0 0 0 1",
                     illegal, out_valid, out_alu_signal, out_imm, out_func_code, in_ready);
        end
        step();
        n_tests++;
        if (illegal !== 1'b0 || out_valid !== 1'b1) begin
            n_fail++; $display("FAIL illegal_pulse: got illegal=%b valid=%b, required 0 1", illegal, out_valid);
        end
        out_ready = 1'b1;
        step();
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL nop_drain: got valid=%b, required 0", out_valid); end
`endif
    endtask

    task automatic test_random();
        bit exp_ill, ill, push, pop;
        exp_t e;
        logic [31:0] inst;
        q.delete();
        exp_ill = 0;
        for (int c = 0; c < 800; c++) begin
            n_tests++;
            if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2) || illegal !== exp_ill) begin
                n_fail++;
                $display("FAIL rand_ctrl@%0d: got valid=%b ready=%b illegal=%b, required %b %b %b",
                         c, out_valid, in_ready, illegal, q.size() > 0, q.size() < 2, exp_ill);
            end
            if (q.size() > 0) begin
                n_tests++;
                if ((obs & q[0].m) !== (q[0].v & q[0].m)) begin
                    n_fail++;
                    $display("FAIL rand_data@%0d: got %h, required %h", c, obs & q[0].m, q[0].v & q[0].m);
                end
            end
            inst = $urandom;
`ifdef ILLEGAL_HALT_EN
            inst[6:0] = legal_ops[$urandom_range(0, 8)];
`else
            if ($urandom_range(0, 9) == 0) inst[6:0] = $urandom_range(0, 1) ? 7'h7F : 7'h00;
            else inst[6:0] = legal_ops[$urandom_range(0, 8)];
`endif
            in_inst   = inst;
            in_pc     = $urandom;
            in_valid  = $urandom_range(0, 2) != 0;
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 29) == 0;
            push = in_valid && (q.size() < 2);
            pop  = out_ready && (q.size() > 0);
            e.v = model(inst, in_pc, ill);
            e.m = full_mask(ill);
            if (flush) begin
                q.delete();
                exp_ill = 0;
            end else begin
                if (pop) void'(q.pop_front());
                if (push) q.push_back(e);
                exp_ill = push && ill;
            end
            step();
        end
        flush = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_vectors();
        test_backpressure();
        test_flush();
        test_illegal();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_decoder.md
ALU_DECODER -- requirements
Module: alu_decoder

Interface
REQ-001 Parameter LEN, default 32, datapath width of pc and imm.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 flush  input  1  synchronous discard of all held entries.
REQ-005 in_valid  input  1  in_inst/in_pc valid this cycle.
REQ-006 in_ready  output  1  decoder accepts; registered, never combinational from out_ready.
REQ-007 in_inst  input  32  RV32I instruction word.
REQ-008 in_pc  input  LEN  pc of in_inst.
REQ-009 out_valid  output  1  head entry valid toward ALU stage.
REQ-010 out_ready  input  1  ALU stage consumes head entry.
REQ-011 out_alu_signal  output  3  NOP=0, BINARY=1, IMM_BINARY=2, BRANCH_COND=3, MEM_ADDR=4, PC_BASED=5, IMM=6.
REQ-012 out_func_code  output  4  {inst[30], inst[14:12]} for OP; {0, inst[14:12]} otherwise.
REQ-013 out_imm  output  LEN  sign-extended immediate; 0 for OP.
REQ-014 out_pc  output  LEN  pc of head entry.
REQ-015 out_rs1, out_rs2, out_rd  output  5 each  inst[19:15], inst[24:20], inst[11:7].
REQ-016 illegal  output  1  unsupported opcode indication.

Function
REQ-017 Transfer on input when in_valid&&in_ready; on output when out_valid&&out_ready.
REQ-018 Opcode map: 0110011->BINARY; 0010011->IMM_BINARY, I-imm; 1100011->BRANCH_COND, B-imm; 0000011->MEM_ADDR, I-imm; 0100011->MEM_ADDR, S-imm; 1100111 (JALR)->MEM_ADDR, I-imm; 0010111->PC_BASED, U-imm; 1101111->PC_BASED, J-imm; 0110111->IMM, U-imm; any other opcode is illegal.
REQ-019 U-imm = {inst[31:12], 12'b0}; B/J/I/S immediates sign-extended from inst[31] to LEN bits.
REQ-020 Two-entry in-order buffer (head + skid); state machine EMPTY, ONE, TWO, HALT.
REQ-021 EMPTY: accept -> ONE; ONE: accept without drain -> TWO, drain without accept -> EMPTY, both -> ONE.
REQ-022 TWO: in_ready=0; drain -> ONE with skid entry promoted to head the same edge.
REQ-023 Latency: instruction accepted at edge N appears on out_* at N (visible cycle N+1) when buffer was empty.
REQ-024 out_* hold stable while out_valid=1 and out_ready=0.
REQ-025 in_ready=1 in EMPTY and ONE, 0 in TWO and HALT.
REQ-026 flush: next state EMPTY, out_valid=0, illegal cleared; flush overrides simultaneous accept (input dropped) and drain.
REQ-027 Order preserved: outputs leave in exact acceptance order, no duplication, no loss.

Reset
REQ-028 rst_n low asynchronously forces state EMPTY, out_valid=0, in_ready=1 after release, illegal=0, out_alu_signal=0, out_func_code=0, out_imm=0, out_pc=0, out_rs1/rs2/rd=0.
REQ-029 Reset mid-transfer discards all held entries; no output transfer completes in the reset cycle.

Configuration
REQ-030 Macro ILLEGAL_HALT_EN compiled in: illegal opcode accepted -> entry not enqueued, state HALT, illegal held 1 until flush or reset; earlier entries still drain.
REQ-031 Without ILLEGAL_HALT_EN: illegal opcode enqueued as NOP (alu_signal=0, imm=0, func_code=0), illegal pulses 1 for one cycle after acceptance, no HALT state.

Verification
REQ-032 in_inst=0x00500093, pc=0x100, out_ready=1 -> next cycle out_valid=1, alu_signal=2, func_code=0, imm=5, rd=1, pc=0x100.
REQ-033 in_inst=0x402081B3 -> alu_signal=1, func_code=4'b1000, rs1=1, rs2=2, rd=3, imm=0.
REQ-034 in_inst=0xFE000EE3 -> alu_signal=3, imm=0xFFFFFFFC; in_inst=0x123451B7 -> alu_signal=6, imm=0x12345000.
REQ-035 out_ready=0, push A then B -> in_ready=0 after B; raise out_ready -> A then B on consecutive cycles, outputs stable while stalled.
REQ-036 ILLEGAL_HALT_EN defined, in_inst=0xFFFFFFFF -> illegal=1, in_ready=0 held; flush -> EMPTY, illegal=0, in_ready=1; macro undefined -> NOP entry, one-cycle illegal pulse.
